// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-requester RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ram_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  // Which requester a command / read return belongs to.
  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  // One requester transaction as presented on the request ports.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_A) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of requester A/B handshake ports and the single-port RAM port.
// Latency: n/a (wires only).
// Backpressure: a requester holds req until its gnt; no other flow control.
// slave  : arbiter side (takes requests and ram_data_out, drives grants/returns/RAM command)
// master : requester + RAM side (drives requests and ram_data_out)
interface ram_arbiter_if #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_wr_en, ram_rd_en, ram_addr, ram_data_in,
    input  ram_data_out
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_wr_en, ram_rd_en, ram_addr, ram_data_in,
    output ram_data_out
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with its priority pointer.
// Latency: grants are combinational from req and pri; pri updates on the next edge.
// Backpressure: a non-granted requester simply keeps req high and wins next time it contends.
// Ports: clk, rst (sync, active-high); i_a_req/i_b_req in; o_a_gnt/o_b_gnt/o_gnt_own out.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_a_req,
  input  logic   i_b_req,
  output logic   o_a_gnt,
  output logic   o_b_gnt,
  output owner_t o_gnt_own
);

  owner_t r_pri;
  owner_t w_pri_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pri <= OWN_A;
    end else begin
      r_pri <= w_pri_nxt;
    end
  end

  // A lone requester wins regardless of pri; on contention pri decides.
  // After any grant the pointer moves to the loser; grants are gated by rst.
  always_comb begin
    o_a_gnt   = 1'b0;
    o_b_gnt   = 1'b0;
    o_gnt_own = OWN_A;
    w_pri_nxt = r_pri;
    if (!rst) begin
      if (i_a_req && (!i_b_req || r_pri == OWN_A)) begin
        o_a_gnt   = 1'b1;
        o_gnt_own = OWN_A;
        w_pri_nxt = other_owner(OWN_A);
      end else if (i_b_req) begin
        o_b_gnt   = 1'b1;
        o_gnt_own = OWN_B;
        w_pri_nxt = other_owner(OWN_B);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one synchronous single-port RAM, routing read data back.
// Latency: grant cycle N -> RAM command in N+1 -> rvalid/rdata in N+2; one grant per cycle.
// Backpressure: the loser keeps req high; the pipeline itself never stalls.
// Ports: clk, rst (sync, active-high); bus = ram_arbiter_if.slave (requests A/B, grants,
//        read returns, RAM wr_en/rd_en/addr/data_in out, ram_data_out in).
module ram_arbiter #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  ram_arbiter_if.slave   bus
);
  import ram_arb_pkg::*;

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_gnt;
  owner_t            w_gnt_own;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Command stage: what the RAM sees in the cycle after a grant.
  logic              r_wr_en;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data_in;
  owner_t            r_cmd_own;

  // Return stage: marks the cycle in which ram_data_out holds read data.
  logic              r_rd_vld;
  owner_t            r_rd_own;

  logic              w_a_rvalid;
  logic              w_b_rvalid;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .i_a_req   (bus.a_req),
    .i_b_req   (bus.b_req),
    .o_a_gnt   (w_a_gnt),
    .o_b_gnt   (w_b_gnt),
    .o_gnt_own (w_gnt_own)
  );

  assign w_gnt       = w_a_gnt | w_b_gnt;
  assign w_sel_we    = (w_gnt_own == OWN_A) ? bus.a_we    : bus.b_we;
  assign w_sel_addr  = (w_gnt_own == OWN_A) ? bus.a_addr  : bus.b_addr;
  assign w_sel_wdata = (w_gnt_own == OWN_A) ? bus.a_wdata : bus.b_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_data_in <= '0;
      r_cmd_own <= OWN_A;
    end else begin
      r_wr_en <= w_gnt & w_sel_we;
      r_rd_en <= w_gnt & ~w_sel_we;
      // Address/data only move on a grant so idle cycles leave the RAM bus quiet.
      if (w_gnt) begin
        r_addr    <= w_sel_addr;
        r_data_in <= w_sel_wdata;
        r_cmd_own <= w_gnt_own;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
      r_rd_own <= OWN_A;
    end else begin
      r_rd_vld <= r_rd_en;
      r_rd_own <= r_cmd_own;
    end
  end

  assign w_a_rvalid = r_rd_vld & (r_rd_own == OWN_A);
  assign w_b_rvalid = r_rd_vld & (r_rd_own == OWN_B);

  // Hold registers keep the last returned word visible while rvalid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      if (w_a_rvalid) r_a_rdata <= bus.ram_data_out;
      if (w_b_rvalid) r_b_rdata <= bus.ram_data_out;
    end
  end

  assign bus.a_gnt       = w_a_gnt;
  assign bus.b_gnt       = w_b_gnt;
  assign bus.a_rvalid    = w_a_rvalid;
  assign bus.b_rvalid    = w_b_rvalid;
  // During the return cycle the RAM output is passed straight through to hit 2-cycle latency.
  assign bus.a_rdata     = w_a_rvalid ? bus.ram_data_out : r_a_rdata;
  assign bus.b_rdata     = w_b_rvalid ? bus.ram_data_out : r_b_rdata;
  assign bus.ram_wr_en   = r_wr_en;
  assign bus.ram_rd_en   = r_rd_en;
  assign bus.ram_addr    = r_addr;
  assign bus.ram_data_in = r_data_in;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a reference model.
// Latency: checks grants every cycle, RAM command one cycle later, read returns two cycles later.
// Backpressure: stimulus holds/drops req per directed step.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter_if bus ();

  ram_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural synchronous RAM: read data appears the cycle after rd_en.
  logic [DATA_W-1:0] ram_mem [2**ADDR_W];
  initial begin
    bus.ram_data_out = '0;
    for (int i = 0; i < 2**ADDR_W; i++) ram_mem[i] = '0;
  end
  always @(posedge clk) begin
    if (bus.ram_wr_en) ram_mem[bus.ram_addr] <= bus.ram_data_in;
    if (bus.ram_rd_en) bus.ram_data_out <= ram_mem[bus.ram_addr];
  end

  // Reference model state.
  typedef struct {
    owner_t            own;
    logic [DATA_W-1:0] data;
    int                due;
  } sb_t;

  sb_t               sb [$];
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  owner_t            m_pri = OWN_A;
  logic              m_wr = 1'b0;
  logic              m_rd = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_din = '0;
  logic [DATA_W-1:0] m_hold_a = '0;
  logic [DATA_W-1:0] m_hold_b = '0;

  initial for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Per-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic              eg_a, eg_b, ev_a, ev_b;
    logic [DATA_W-1:0] ed_a, ed_b;
    sb_t               e;
    req_t              g;
    eg_a = 1'b0;
    eg_b = 1'b0;
    if (!rst) begin
      if (bus.a_req && (!bus.b_req || m_pri == OWN_A)) eg_a = 1'b1;
      else if (bus.b_req) eg_b = 1'b1;
    end
    chk("a_gnt", 32'(bus.a_gnt), 32'(eg_a));
    chk("b_gnt", 32'(bus.b_gnt), 32'(eg_b));
    chk("gnt_excl", 32'(bus.a_gnt & bus.b_gnt), 32'(0));
    chk("wr_rd_excl", 32'(bus.ram_wr_en & bus.ram_rd_en), 32'(0));
    chk("ram_wr_en", 32'(bus.ram_wr_en), 32'(m_wr));
    chk("ram_rd_en", 32'(bus.ram_rd_en), 32'(m_rd));
    chk("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
    chk("ram_data_in", 32'(bus.ram_data_in), 32'(m_din));

    ev_a = 1'b0;
    ev_b = 1'b0;
    ed_a = m_hold_a;
    ed_b = m_hold_b;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (e.own == OWN_A) begin ev_a = 1'b1; ed_a = e.data; end
      else                begin ev_b = 1'b1; ed_b = e.data; end
    end
    chk("a_rvalid", 32'(bus.a_rvalid), 32'(ev_a));
    chk("b_rvalid", 32'(bus.b_rvalid), 32'(ev_b));
    chk("a_rdata", 32'(bus.a_rdata), 32'(ed_a));
    chk("b_rdata", 32'(bus.b_rdata), 32'(ed_b));

    if (rst) begin
      m_pri = OWN_A;
      sb.delete();
      m_wr = 1'b0; m_rd = 1'b0; m_addr = '0; m_din = '0;
      m_hold_a = '0; m_hold_b = '0;
    end else begin
      if (eg_a || eg_b) begin
        if (eg_a) g = '{bus.a_we, bus.a_addr, bus.a_wdata};
        else      g = '{bus.b_we, bus.b_addr, bus.b_wdata};
        m_pri  = eg_a ? OWN_B : OWN_A;
        m_wr   = g.we;
        m_rd   = ~g.we;
        m_addr = g.addr;
        m_din  = g.wdata;
        if (g.we) ref_mem[g.addr] = g.wdata;
        else sb.push_back('{eg_a ? OWN_A : OWN_B, ref_mem[g.addr], cyc + 2});
      end else begin
        m_wr = 1'b0;
        m_rd = 1'b0;
      end
      if (ev_a) m_hold_a = ed_a;
      if (ev_b) m_hold_b = ed_b;
    end
  end

  function automatic req_t wr(input int a, input int d);
    return '{1'b1, ADDR_W'(a), DATA_W'(d)};
  endfunction

  function automatic req_t rd(input int a);
    return '{1'b0, ADDR_W'(a), DATA_W'(0)};
  endfunction

  // Apply one cycle of requests, then move to just after the next rising edge.
  task automatic drive(input logic ar, input req_t ra, input logic br, input req_t rb);
    bus.a_req   = ar;
    bus.a_we    = ra.we;
    bus.a_addr  = ra.addr;
    bus.a_wdata = ra.wdata;
    bus.b_req   = br;
    bus.b_we    = rb.we;
    bus.b_addr  = rb.addr;
    bus.b_wdata = rb.wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rd(0), 1'b0, rd(0));
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Write then read-back of the same address by A.
    drive(1'b1, wr(3, 8'hA5), 1'b0, rd(0));
    drive(1'b1, rd(3),        1'b0, rd(0));
    idle(3);

    // Seed two addresses, then both requesters read continuously.
    drive(1'b1, wr(1, 8'h11), 1'b0, rd(0));
    drive(1'b0, rd(0),        1'b1, wr(2, 8'h22));
    for (int i = 0; i < 6; i++) drive(1'b1, rd(1), 1'b1, rd(2));
    idle(3);

    // B alone three times, then contention: A must win.
    for (int i = 0; i < 3; i++) drive(1'b0, rd(0), 1'b1, rd(2));
    drive(1'b1, rd(1), 1'b1, rd(2));
    idle(3);

    // A writes the top address, B reads it the very next cycle.
    drive(1'b1, wr(31, 8'h3C), 1'b0, rd(0));
    drive(1'b0, rd(0),         1'b1, rd(31));
    idle(3);

    // Reset lands the cycle after a read grant: the read must vanish.
    drive(1'b1, rd(3), 1'b0, rd(0));
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    drive(1'b1, rd(1), 1'b1, rd(2));
    idle(3);

    // Mixed random traffic on a small address window to provoke hazards.
    for (int i = 0; i < 24; i++) begin
      drive(1'($urandom_range(0, 1)),
            '{1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom)},
            1'($urandom_range(0, 1)),
            '{1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom)});
    end
    idle(1);

    // Bounded drain of outstanding reads.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
